// File: rtl/mae_evaluator.sv
`default_nettype none
//============================================================================
// Module      : mae_evaluator
// Description : Exhaustive error evaluator for a combinational approximate
//               adder. Sweeps every operand pair, drives it to the adder
//               under test and accumulates the sum of absolute errors, the
//               worst-case absolute error and the count of erroneous pairs.
// Revision    : 1.0 - initial release
//============================================================================
module mae_evaluator #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic [WIDTH-1:0]     IN1,
    output logic [WIDTH-1:0]     IN2,
    input  logic [WIDTH:0]       approx_sum,
    output logic                 busy,
    output logic                 done,
    output logic [3*WIDTH:0]     err_sum,
    output logic [WIDTH:0]       max_err,
    output logic [2*WIDTH:0]     err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [2*WIDTH-1:0]    pair_q, pair_d;
    logic [3*WIDTH:0]      err_sum_q, err_sum_d;
    logic [WIDTH:0]        max_err_q, max_err_d;
    logic [2*WIDTH:0]      err_cnt_q, err_cnt_d;

    logic [WIDTH:0]        w_exact;
    logic signed [WIDTH+1:0] w_diff;
    logic [WIDTH:0]        w_abs_err;
    logic                  w_last_pair;

    // Absolute error of the pair currently presented; the signed intermediate
    // is one bit wider than the sums so the difference never wraps.
    always_comb begin
        w_exact     = {1'b0, pair_q[2*WIDTH-1:WIDTH]} + {1'b0, pair_q[WIDTH-1:0]};
        w_diff      = $signed({1'b0, w_exact}) - $signed({1'b0, approx_sum});
        w_abs_err   = w_diff[WIDTH+1] ? (~w_diff[WIDTH:0] + 1'b1) : w_diff[WIDTH:0];
        w_last_pair = &pair_q;
    end

    // Next-state and accumulator update; registers hold unless changed below.
    always_comb begin
        state_d   = state_q;
        pair_d    = pair_q;
        err_sum_d = err_sum_q;
        max_err_d = max_err_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_SWEEP;
                    pair_d    = '0;
                    err_sum_d = '0;
                    max_err_d = '0;
                    err_cnt_d = '0;
                end
            end
            S_SWEEP: begin
                if (abort) begin
                    // Leave without folding in the pair on the bus this cycle.
                    state_d = S_IDLE;
                end else begin
                    err_sum_d = err_sum_q + {{(2*WIDTH){1'b0}}, w_abs_err};
                    if (w_abs_err > max_err_q) begin
                        max_err_d = w_abs_err;
                    end
                    err_cnt_d = err_cnt_q + {{(2*WIDTH){1'b0}}, (w_abs_err != '0)};
                    if (w_last_pair) begin
                        // Keep the final operands on the bus while results are shown.
                        state_d = S_DONE;
                    end else begin
                        pair_d = pair_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pair_q    <= '0;
            err_sum_q <= '0;
            max_err_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pair_q    <= pair_d;
            err_sum_q <= err_sum_d;
            max_err_q <= max_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign IN1     = pair_q[2*WIDTH-1:WIDTH];
    assign IN2     = pair_q[WIDTH-1:0];
    assign busy    = (state_q == S_SWEEP);
    assign done    = (state_q == S_DONE);
    assign err_sum = err_sum_q;
    assign max_err = max_err_q;
    assign err_cnt = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mae_evaluator.sv
`default_nettype none
//============================================================================
// Module      : tb_mae_evaluator
// Description : Self-checking bench for mae_evaluator. A WIDTH=4 instance
//               runs a table of adder models and the abort/reset corner
//               cases; a WIDTH=8 instance runs one full 65536-pair sweep.
// Revision    : 1.0 - initial release
//============================================================================
module tb_mae_evaluator;

    localparam int W4 = 4;
    localparam int W8 = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- WIDTH=4 instance ----------------
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [W4-1:0]   in1, in2;
    logic [W4:0]     approx;
    logic            busy, done;
    logic [3*W4:0]   err_sum;
    logic [W4:0]     max_err;
    logic [2*W4:0]   err_cnt;
    int              model = 0;

    mae_evaluator #(.WIDTH(W4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .IN1(in1), .IN2(in2), .approx_sum(approx),
        .busy(busy), .done(done),
        .err_sum(err_sum), .max_err(max_err), .err_cnt(err_cnt)
    );

    // Adder models: 0 exact, 1 LSB flipped, 2 constant zero,
    // 3 LSB cleared, 4 carry-out dropped.
    always_comb begin
        logic [W4:0] ex;
        ex = {1'b0, in1} + {1'b0, in2};
        case (model)
            1:       approx = ex ^ 5'd1;
            2:       approx = '0;
            3:       approx = ex & 5'h1E;
            4:       approx = ex & 5'h0F;
            default: approx = ex;
        endcase
    end

    // ---------------- WIDTH=8 instance ----------------
    logic            rst8_n = 1'b0;
    logic            start8 = 1'b0;
    logic            abort8 = 1'b0;
    logic [W8-1:0]   in1_8, in2_8;
    logic [W8:0]     approx8 = '0;
    logic            busy8, done8;
    logic [3*W8:0]   err_sum8;
    logic [W8:0]     max_err8;
    logic [2*W8:0]   err_cnt8;
    bit              fin8 = 1'b0;

    mae_evaluator #(.WIDTH(W8)) u_dut8 (
        .clk(clk), .rst_n(rst8_n), .start(start8), .abort(abort8),
        .IN1(in1_8), .IN2(in2_8), .approx_sum(approx8),
        .busy(busy8), .done(done8),
        .err_sum(err_sum8), .max_err(max_err8), .err_cnt(err_cnt8)
    );

    // Full-width sweep against a constant-zero adder.
    initial begin
        int cyc;
        repeat (3) @(posedge clk);
        #1 rst8_n = 1'b1;
        @(posedge clk); #1 start8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
        cyc = busy8 ? 1 : 0;
        while (busy8 && cyc < 70000) begin
            @(posedge clk); #1;
            if (busy8) cyc++;
        end
        check("w8_sweep_cycles", cyc, 65536);
        check("w8_done", done8, 1);
        check("w8_err_sum", err_sum8, 16711680);
        check("w8_max_err", max_err8, 510);
        check("w8_err_cnt", err_cnt8, 65535);
        fin8 = 1'b1;
    end

    // Start a sweep, confirm the cleared state on its first cycle, and count
    // SWEEP cycles until done. With hold set, start stays high until done.
    task automatic run_sweep(input bit hold, output int cyc);
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        check("first_busy", busy, 1);
        check("first_err_sum", err_sum, 0);
        check("first_max_err", max_err, 0);
        check("first_err_cnt", err_cnt, 0);
        check("first_operands", {in1, in2}, 0);
        cyc = 1;
        while (busy && cyc < 1000) begin
            @(posedge clk); #1;
            if (busy) cyc++;
        end
        start = 1'b0;
    endtask

    typedef struct {
        int model;
        int exp_sum;
        int exp_max;
        int exp_cnt;
    } vec_t;

    initial begin
        vec_t vecs[5];
        int   cyc;
        int   guard;

        vecs[0] = '{0,    0,  0,   0};
        vecs[1] = '{1,  256,  1, 256};
        vecs[2] = '{2, 3840, 30, 255};
        vecs[3] = '{3,  128,  1, 128};
        vecs[4] = '{4, 1920, 16, 120};

        // Reset state
        repeat (2) @(posedge clk); #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err_sum", err_sum, 0);
        check("rst_max_err", max_err, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_operands", {in1, in2}, 0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk); #1;
        check("idle_no_autostart", busy, 0);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        check("idle_abort_ignored", {busy, done}, 0);

        // Table of models; successive starts also exercise restart from DONE
        for (int i = 0; i < 5; i++) begin
            model = vecs[i].model;
            run_sweep(1'b0, cyc);
            check($sformatf("v%0d_cycles", i), cyc, 256);
            check($sformatf("v%0d_done", i), done, 1);
            check($sformatf("v%0d_err_sum", i), err_sum, vecs[i].exp_sum);
            check($sformatf("v%0d_max_err", i), max_err, vecs[i].exp_max);
            check($sformatf("v%0d_err_cnt", i), err_cnt, vecs[i].exp_cnt);
            check($sformatf("v%0d_operands", i), {in1, in2}, 8'hFF);
            repeat (3) @(posedge clk); #1;
            check($sformatf("v%0d_hold", i), {done, err_sum}, {1'b1, 13'(vecs[i].exp_sum)});
        end

        // Start held high through the sweep: a single sweep only
        model = 1;
        run_sweep(1'b1, cyc);
        check("hold_cycles", cyc, 256);
        check("hold_err_sum", err_sum, 256);
        repeat (3) @(posedge clk); #1;
        check("hold_no_restart", {busy, done}, 2'b01);

        // Abort after 100 processed pairs
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (100) @(posedge clk);
        #1 abort = 1'b1; start = 1'b1;
        @(posedge clk); #1 abort = 1'b0; start = 1'b0;
        check("abort_state", {busy, done}, 0);
        check("abort_err_sum", err_sum, 100);
        check("abort_err_cnt", err_cnt, 100);
        check("abort_operands", {in1, in2}, 100);
        repeat (3) @(posedge clk); #1;
        check("abort_hold", {busy, done, err_sum, in1, in2}, {2'b00, 13'd100, 8'd100});
        run_sweep(1'b0, cyc);
        check("post_abort_cycles", cyc, 256);
        check("post_abort_err_sum", err_sum, 256);
        check("post_abort_max_err", max_err, 1);
        check("post_abort_err_cnt", err_cnt, 256);

        // Abort on the last pair wins over the move to DONE
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (255) @(posedge clk);
        #1 check("last_pair_operands", {in1, in2}, 8'hFF);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        check("last_abort_state", {busy, done}, 0);
        check("last_abort_err_sum", err_sum, 255);

        // Asynchronous reset mid-sweep
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (50) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_outputs", {busy, done, err_sum, max_err, err_cnt, in1, in2}, 0);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk); #1;
        check("post_rst_idle", {busy, done, err_sum}, 0);

        guard = 0;
        while (!fin8 && guard < 80000) begin
            @(posedge clk);
            guard++;
        end
        check("w8_finished", fin8, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
